// File: rtl/sim_ctrl_multi.sv
// Simulation-control supervisor: staggered multi-channel reset release, heartbeat and end-of-test supervision.
// Optional build macro SIM_CTRL_MULTI_DISPLAY_EN adds simulation-only messages and a $finish on entering DONE.

module sim_ctrl_multi #(
    parameter int RST_CH_N        = 2,
    parameter int CYC_W           = 32,
    parameter int RST_BASE_CYCLES = 5,
    parameter int DRAIN_CYCLES    = 4,
    parameter int CFG_W           = 32
) (
    input  logic                sim_ctrl_multi_clk_ip,
    input  logic                sim_ctrl_multi_rst_n_ip,
    input  logic                sim_ctrl_multi_cfg_we_ip,
    input  logic [1:0]          sim_ctrl_multi_cfg_addr_ip,
    input  logic [CFG_W-1:0]    sim_ctrl_multi_cfg_wdata_ip,
    input  logic                sim_ctrl_multi_kick_ip,
    input  logic                sim_ctrl_multi_pass_req_ip,
    output logic [RST_CH_N-1:0] sim_ctrl_multi_rst_op,
    output logic [CYC_W-1:0]    sim_ctrl_multi_cycles_op,
    output logic                sim_ctrl_multi_hb_op,
    output logic                sim_ctrl_multi_done_op,
    output logic [1:0]          sim_ctrl_multi_status_op
);

    localparam int THR_W      = CYC_W + 5;
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1'b1);
    localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CFG_W-1:0] CFG_ONE  = CFG_W'(1'b1);
    localparam logic [CFG_W-1:0] CFG_ZERO = {CFG_W{1'b0}};

    localparam logic [1:0] ADDR_TIMEOUT = 2'd0;
    localparam logic [1:0] ADDR_HB      = 2'd1;
    localparam logic [1:0] ADDR_WD      = 2'd2;
    localparam logic [1:0] ADDR_STAGGER = 2'd3;

    localparam logic [1:0] STAT_RUNNING = 2'd0;
    localparam logic [1:0] STAT_PASS    = 2'd1;
    localparam logic [1:0] STAT_TIMEOUT = 2'd2;
    localparam logic [1:0] STAT_WDOG    = 2'd3;

    typedef enum logic [1:0] {
        ST_SEQ   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CYC_W-1:0]    cycles_r, cycles_s, idle_r, idle_s;
    logic [31:0]         drain_cnt_r, drain_cnt_s;
    logic [CFG_W-1:0]    timeout_r, timeout_s, hb_period_r, hb_period_s;
    logic [CFG_W-1:0]    wd_limit_r, wd_limit_s, stagger_r, stagger_s;
    logic [CFG_W-1:0]    hb_cnt_r, hb_cnt_s;
    logic [RST_CH_N-1:0] rst_r, rst_s;
    logic                hb_r, hb_s, done_r, done_s;
    logic [1:0]          status_r, status_s, evt_code_s;
    logic                active_s, cfg_ok_s, to_hit_s, wd_hit_s, pass_hit_s, evt_s;

    // Channel ch stays in reset while the cycle count is below this threshold.
    function automatic logic [THR_W-1:0] release_thr(input int ch, input logic [CFG_W-1:0] stagger);
        release_thr = THR_W'(RST_BASE_CYCLES) + THR_W'(ch) * THR_W'(stagger);
    endfunction

    // Datapath next values: counters, config registers and end-event detection.
    always_comb begin
        active_s    = (state_r != ST_DONE);
        cfg_ok_s    = sim_ctrl_multi_cfg_we_ip && active_s;
        timeout_s   = timeout_r;
        hb_period_s = hb_period_r;
        wd_limit_s  = wd_limit_r;
        stagger_s   = stagger_r;
        if (cfg_ok_s) begin
            case (sim_ctrl_multi_cfg_addr_ip)
                ADDR_TIMEOUT: timeout_s   = sim_ctrl_multi_cfg_wdata_ip;
                ADDR_HB:      hb_period_s = sim_ctrl_multi_cfg_wdata_ip;
                ADDR_WD:      wd_limit_s  = sim_ctrl_multi_cfg_wdata_ip;
                ADDR_STAGGER: stagger_s   = sim_ctrl_multi_cfg_wdata_ip;
                default:      timeout_s   = timeout_r;
            endcase
        end else begin
            timeout_s = timeout_r;
        end

        if (active_s && (cycles_r != CYC_MAX)) begin
            cycles_s = cycles_r + CYC_ONE;
        end else begin
            cycles_s = cycles_r;
        end

        // A kick wins over counting so the idle count restarts at zero on the kick edge.
        if (sim_ctrl_multi_kick_ip) begin
            idle_s = CYC_ZERO;
        end else if ((state_r == ST_RUN) && (idle_r != CYC_MAX)) begin
            idle_s = idle_r + CYC_ONE;
        end else begin
            idle_s = idle_r;
        end

        if (cfg_ok_s && (sim_ctrl_multi_cfg_addr_ip == ADDR_HB)) begin
            hb_cnt_s = sim_ctrl_multi_cfg_wdata_ip - CFG_ONE;
        end else if (active_s) begin
            hb_cnt_s = (hb_cnt_r == CFG_ZERO) ? (hb_period_r - CFG_ONE) : (hb_cnt_r - CFG_ONE);
        end else begin
            hb_cnt_s = hb_cnt_r;
        end

        if (state_r == ST_DRAIN) begin
            drain_cnt_s = drain_cnt_r + 32'd1;
        end else begin
            drain_cnt_s = 32'd0;
        end

        to_hit_s   = (timeout_r != CFG_ZERO) && (cycles_s == CYC_W'(timeout_r));
        wd_hit_s   = (wd_limit_r != CFG_ZERO) && (idle_s == CYC_W'(wd_limit_r));
        pass_hit_s = sim_ctrl_multi_pass_req_ip && (state_r == ST_RUN);
        evt_s      = ((state_r == ST_SEQ) || (state_r == ST_RUN)) && (to_hit_s || wd_hit_s || pass_hit_s);
        if (wd_hit_s) begin
            evt_code_s = STAT_WDOG;
        end else if (to_hit_s) begin
            evt_code_s = STAT_TIMEOUT;
        end else begin
            evt_code_s = STAT_PASS;
        end
    end

    // State register.
    always_ff @(posedge sim_ctrl_multi_clk_ip or negedge sim_ctrl_multi_rst_n_ip) begin
        if (!sim_ctrl_multi_rst_n_ip) begin
            state_r <= ST_SEQ;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SEQ: begin
                if (evt_s) begin
                    state_s = ST_DRAIN;
                end else if (rst_r == {RST_CH_N{1'b0}}) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SEQ;
                end
            end
            ST_RUN: begin
                if (evt_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 32'(DRAIN_LAST)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_SEQ;
        endcase
    end

    // Output next values, computed against post-edge counts so outputs line up with cycles_op.
    always_comb begin
        if (evt_s) begin
            status_s = evt_code_s;
        end else begin
            status_s = status_r;
        end
        done_s = (state_s == ST_DONE);
        hb_s   = (state_s != ST_DONE) && (hb_period_s != CFG_ZERO) && (hb_cnt_s == CFG_ZERO);
        rst_s  = rst_r;
        for (int i = 0; i < RST_CH_N; i++) begin
            rst_s[i] = rst_r[i] && (state_s == ST_SEQ) && (THR_W'(cycles_s) < release_thr(i, stagger_s));
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sim_ctrl_multi_clk_ip or negedge sim_ctrl_multi_rst_n_ip) begin
        if (!sim_ctrl_multi_rst_n_ip) begin
            cycles_r    <= CYC_ZERO;
            idle_r      <= CYC_ZERO;
            drain_cnt_r <= 32'd0;
            timeout_r   <= CFG_ZERO;
            hb_period_r <= CFG_W'(10'd1000);
            wd_limit_r  <= CFG_ZERO;
            stagger_r   <= CFG_ONE;
            hb_cnt_r    <= CFG_W'(10'd999);
            rst_r       <= {RST_CH_N{1'b1}};
            hb_r        <= 1'b0;
            done_r      <= 1'b0;
            status_r    <= STAT_RUNNING;
        end else begin
            cycles_r    <= cycles_s;
            idle_r      <= idle_s;
            drain_cnt_r <= drain_cnt_s;
            timeout_r   <= timeout_s;
            hb_period_r <= hb_period_s;
            wd_limit_r  <= wd_limit_s;
            stagger_r   <= stagger_s;
            hb_cnt_r    <= hb_cnt_s;
            rst_r       <= rst_s;
            hb_r        <= hb_s;
            done_r      <= done_s;
            status_r    <= status_s;
        end
    end

    assign sim_ctrl_multi_rst_op    = rst_r;
    assign sim_ctrl_multi_cycles_op = cycles_r;
    assign sim_ctrl_multi_hb_op     = hb_r;
    assign sim_ctrl_multi_done_op   = done_r;
    assign sim_ctrl_multi_status_op = status_r;

`ifdef SIM_CTRL_MULTI_DISPLAY_EN
    // Simulation-only trace of heartbeats, config writes and the end of the run.
    always @(posedge sim_ctrl_multi_clk_ip) begin
        if (sim_ctrl_multi_rst_n_ip) begin
            if (hb_r) begin
                $display("%m : %10d cycles", cycles_r);
            end
            if (cfg_ok_s) begin
                $display("%m : config write addr %0d data %0d", sim_ctrl_multi_cfg_addr_ip, sim_ctrl_multi_cfg_wdata_ip);
            end
            if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
                $display("End of simulation at %d status %d", cycles_s, status_s);
                $finish;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_ctrl_multi.sv
// Directed self-checking bench for sim_ctrl_multi: a 2-channel and a 4-channel instance share stimulus.
module tb_sim_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        kick;
    logic        pass_req;

    logic [1:0]  rst2;
    logic [31:0] cyc2;
    logic        hb2, done2;
    logic [1:0]  st2;
    logic [3:0]  rst4;
    logic [31:0] cyc4;
    logic        hb4, done4;
    logic [1:0]  st4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sim_ctrl_multi #(.RST_CH_N(2)) u_dut2 (
        .sim_ctrl_multi_clk_ip      (clk),
        .sim_ctrl_multi_rst_n_ip    (rst_n),
        .sim_ctrl_multi_cfg_we_ip   (cfg_we),
        .sim_ctrl_multi_cfg_addr_ip (cfg_addr),
        .sim_ctrl_multi_cfg_wdata_ip(cfg_wdata),
        .sim_ctrl_multi_kick_ip     (kick),
        .sim_ctrl_multi_pass_req_ip (pass_req),
        .sim_ctrl_multi_rst_op      (rst2),
        .sim_ctrl_multi_cycles_op   (cyc2),
        .sim_ctrl_multi_hb_op       (hb2),
        .sim_ctrl_multi_done_op     (done2),
        .sim_ctrl_multi_status_op   (st2)
    );

    sim_ctrl_multi #(.RST_CH_N(4)) u_dut4 (
        .sim_ctrl_multi_clk_ip      (clk),
        .sim_ctrl_multi_rst_n_ip    (rst_n),
        .sim_ctrl_multi_cfg_we_ip   (cfg_we),
        .sim_ctrl_multi_cfg_addr_ip (cfg_addr),
        .sim_ctrl_multi_cfg_wdata_ip(cfg_wdata),
        .sim_ctrl_multi_kick_ip     (kick),
        .sim_ctrl_multi_pass_req_ip (pass_req),
        .sim_ctrl_multi_rst_op      (rst4),
        .sim_ctrl_multi_cycles_op   (cyc4),
        .sim_ctrl_multi_hb_op       (hb4),
        .sim_ctrl_multi_done_op     (done4),
        .sim_ctrl_multi_status_op   (st4)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Inputs applied at a negedge are taken by the next posedge, so a write issued while cycles=c applies from c+1.
    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Leaves the bench at a negedge with reset released and cycles=0.
    task automatic apply_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0; kick = 1'b0; pass_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0; kick = 1'b0; pass_req = 1'b0;
        step();
        checks++; if (rst2 !== 2'b11) begin errors++; $display("FAIL reset_rst2 got %b exp 11", rst2); end
        checks++; if (rst4 !== 4'hF) begin errors++; $display("FAIL reset_rst4 got %h exp f", rst4); end
        checks++; if (cyc2 !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d exp 0", cyc2); end
        checks++; if (hb2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_hb_done got %b%b exp 00", hb2, done2); end
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL reset_status got %0d exp 0", st2); end
        rst_n = 1'b1;
        // pass at 6 is sampled in SEQ and dropped; pass at 9 ends the test, DRAIN 10..13, DONE from 14.
        for (int c = 0; c <= 16; c++) begin
            logic [1:0]  er, es;
            logic        ed;
            logic [31:0] ec;
            er = (c < 5) ? 2'b11 : ((c < 6) ? 2'b10 : 2'b00);
            es = (c >= 10) ? 2'd1 : 2'd0;
            ed = (c >= 14);
            ec = (c <= 14) ? 32'(c) : 32'd14;
            checks++; if (rst2 !== er) begin errors++; $display("FAIL seq_rst2 c=%0d got %b exp %b", c, rst2, er); end
            checks++; if (st2 !== es || done2 !== ed) begin errors++; $display("FAIL seq_status c=%0d got %0d/%b exp %0d/%b", c, st2, done2, es, ed); end
            checks++; if (cyc2 !== ec) begin errors++; $display("FAIL seq_cycles c=%0d got %0d exp %0d", c, cyc2, ec); end
            pass_req = (c == 6) || (c == 9);
            step();
        end
        pass_req = 1'b0;
    endtask

    task automatic test_stagger();
        apply_reset();
        step();
        cfg_wr(2'd3, 32'd3);
        for (int c = 2; c <= 20; c++) begin
            logic [3:0] e4;
            logic [1:0] e2;
            e4 = {c < 14, c < 11, c < 8, c < 5};
            e2 = {c < 8, c < 5};
            checks++; if (rst4 !== e4) begin errors++; $display("FAIL stagger_rst4 c=%0d got %b exp %b", c, rst4, e4); end
            checks++; if (rst2 !== e2) begin errors++; $display("FAIL stagger_rst2 c=%0d got %b exp %b", c, rst2, e2); end
            checks++; if (cyc4 !== 32'(c)) begin errors++; $display("FAIL stagger_cycles c=%0d got %0d exp %0d", c, cyc4, c); end
            // A larger stagger after every channel is released must not re-assert anything.
            cfg_we = (c == 15); cfg_addr = 2'd3; cfg_wdata = 32'd10;
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        cfg_wr(2'd0, 32'd20);
        for (int c = 1; c <= 30; c++) begin
            logic [1:0]  es;
            logic        ed;
            logic [31:0] ec;
            es = (c >= 20) ? 2'd2 : 2'd0;
            ed = (c >= 24);
            ec = (c <= 24) ? 32'(c) : 32'd24;
            checks++; if (st2 !== es || st4 !== es) begin errors++; $display("FAIL timeout_status c=%0d got %0d/%0d exp %0d", c, st2, st4, es); end
            checks++; if (done2 !== ed || done4 !== ed) begin errors++; $display("FAIL timeout_done c=%0d got %b/%b exp %b", c, done2, done4, ed); end
            checks++; if (cyc2 !== ec) begin errors++; $display("FAIL timeout_cycles c=%0d got %0d exp %0d", c, cyc2, ec); end
            step();
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        cfg_wr(2'd2, 32'd10);
        // Kicks land at cycles 8,16,24,32,40; idle then reaches 10 at cycles 50.
        for (int c = 1; c <= 60; c++) begin
            logic [1:0] es;
            logic       ed;
            es = (c >= 50) ? 2'd3 : 2'd0;
            ed = (c >= 54);
            checks++; if (st2 !== es) begin errors++; $display("FAIL wdog_status c=%0d got %0d exp %0d", c, st2, es); end
            checks++; if (done2 !== ed) begin errors++; $display("FAIL wdog_done c=%0d got %b exp %b", c, done2, ed); end
            kick     = ((c % 8) == 7) && (c <= 39);
            pass_req = (c == 52);
            step();
        end
        kick = 1'b0; pass_req = 1'b0;
    endtask

    task automatic test_priority();
        // Run 0: timeout, watchdog and pass all at 30; run 1: no watchdog; run 2: timeout at 31.
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            cfg_wr(2'd0, (r == 2) ? 32'd31 : 32'd30);
            cfg_wr(2'd2, (r == 0) ? 32'd23 : 32'd0);
            for (int c = 2; c <= 31; c++) begin
                logic [1:0] e2, e4;
                e2 = (c < 30) ? 2'd0 : ((r == 0) ? 2'd3 : ((r == 1) ? 2'd2 : 2'd1));
                e4 = (c < 30) ? 2'd0 : ((r == 2) ? 2'd1 : 2'd2);
                if (c >= 29) begin
                    checks++; if (st2 !== e2) begin errors++; $display("FAIL prio_status2 r=%0d c=%0d got %0d exp %0d", r, c, st2, e2); end
                    checks++; if (st4 !== e4) begin errors++; $display("FAIL prio_status4 r=%0d c=%0d got %0d exp %0d", r, c, st4, e4); end
                end else begin
                    checks++; if (st2 !== e2) begin errors++; $display("FAIL prio_early r=%0d c=%0d got %0d exp %0d", r, c, st2, e2); end
                end
                pass_req = (c == 29);
                step();
            end
            pass_req = 1'b0;
        end
    endtask

    task automatic test_heartbeat();
        apply_reset();
        cfg_wr(2'd1, 32'd4);
        for (int c = 1; c <= 24; c++) begin
            logic eh;
            eh = (c == 4) || (c == 8) || (c == 12);
            checks++; if (hb2 !== eh || hb4 !== eh) begin errors++; $display("FAIL hb c=%0d got %b/%b exp %b", c, hb2, hb4, eh); end
            cfg_we = (c == 13); cfg_addr = 2'd1; cfg_wdata = 32'd0;
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        apply_reset();
        cfg_wr(2'd0, 32'd10);
        for (int c = 1; c <= 10; c++) begin
            logic [1:0] es;
            es = (c >= 10) ? 2'd2 : 2'd0;
            checks++; if (st2 !== es) begin errors++; $display("FAIL drain_pre c=%0d got %0d exp %0d", c, st2, es); end
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++; if (rst2 !== 2'b11 || rst4 !== 4'hF) begin errors++; $display("FAIL drain_rst got %b/%h exp 11/f", rst2, rst4); end
        checks++; if (st2 !== 2'd0 || done2 !== 1'b0) begin errors++; $display("FAIL drain_status got %0d/%b exp 0/0", st2, done2); end
        checks++; if (cyc2 !== 32'd0) begin errors++; $display("FAIL drain_cycles got %0d exp 0", cyc2); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (done2 !== 1'b0 || rst2 !== 2'b11) begin errors++; $display("FAIL drain_hold k=%0d got %b/%b exp 0/11", k, done2, rst2); end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            logic [1:0] er;
            step();
            er = (c < 5) ? 2'b11 : ((c < 6) ? 2'b10 : 2'b00);
            checks++; if (cyc2 !== 32'(c) || rst2 !== er) begin errors++; $display("FAIL restart c=%0d got %0d/%b exp %0d/%b", c, cyc2, rst2, c, er); end
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_timeout();
        test_watchdog();
        test_priority();
        test_heartbeat();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
